// File: rtl/disp_arbiter.sv
// Round-robin arbiter/sequencer sharing the bargraph pattern and digit-select between NREQ requesters.
// Optional preemption by requester 0 is enabled with the DISP_ARB_PREEMPT_EN macro.
module disp_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 16,
  parameter int HOLD = 100
) (
  input  logic              hz100,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] data,
  output logic [NREQ-1:0]   gnt,
  output logic [2:0]        sel,
  output logic [W-1:0]      out,
  output logic              active,
  output logic [NREQ-1:0]   done
);

  localparam int PW = $clog2(NREQ);
  localparam int TW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [TW-1:0] TLOAD = TW'(HOLD - 1);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t         state;
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  cur;
  logic [TW-1:0]  timer;
  logic [PW-1:0]  win;
  logic [PW-1:0]  ptr_next;
  logic           expire;
  logic           preempt;

  // First set request at or above p, wrapping modulo NREQ.
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
    logic [PW-1:0] pick;
    logic          found;
    int            idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(p) + k) % NREQ;
      if (!found && r[idx]) begin
        pick  = PW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign win      = rr_pick(req, ptr);
  assign ptr_next = (int'(cur) == NREQ - 1) ? '0 : cur + 1'b1;
  assign expire   = !req[cur] || (timer == '0);
  assign sel      = 3'(cur);

`ifdef DISP_ARB_PREEMPT_EN
  assign preempt = (cur != '0) && req[0];
`else
  assign preempt = 1'b0;
`endif

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      ptr    <= '0;
      cur    <= '0;
      timer  <= '0;
      gnt    <= '0;
      out    <= '0;
      active <= 1'b0;
      done   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state  <= GRANT;
            cur    <= win;
            gnt    <= NREQ'(1) << win;
            out    <= data[int'(win)*W +: W];
            active <= 1'b1;
            timer  <= TLOAD;
          end
        end
        GRANT: begin
          if (expire || preempt) begin
            state  <= GAP;
            gnt    <= '0;
            active <= 1'b0;
            out    <= '0;
            done   <= NREQ'(1) << cur;
            ptr    <= preempt ? '0 : ptr_next;
          end else begin
            out   <= data[int'(cur)*W +: W];
            timer <= timer - 1'b1;
          end
        end
        GAP: begin
          // sel is held through GAP and returns to zero with the rest of IDLE
          done  <= '0;
          cur   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
